// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - register-file owner that sequences a shared combinational ALU
// Accepts one instruction at a time, iterates the ALU 1..8 times feeding the result back as op1, writes the result back.
module alu_sequencer #(
  parameter int NREG = 8,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [2:0]   in_rd,
  input  logic [2:0]   in_rs1,
  input  logic [2:0]   in_rs2,
  input  logic [2:0]   in_rep,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [2:0]   rd_addr,
  output logic [W-1:0] rd_data,
  output logic [W-1:0] alu_op1,
  output logic [W-1:0] alu_op2,
  output logic [2:0]   alu_sel,
  input  logic [W-1:0] alu_out,
  input  logic         alu_co,
  output logic         done,
  output logic [W-1:0] done_data,
  output logic         carry,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_rf [NREG];
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [2:0]   r_op;
  logic [2:0]   r_rd;
  logic [2:0]   r_rep;
  logic [2:0]   r_iter;
  logic         r_carry;
  logic         r_done;
  logic         r_err;
  logic [W-1:0] r_done_data;

  logic w_accept;
  logic w_legal;
  logic w_last;
  logic w_carry_op;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_legal    = (in_op != 3'b100) && (in_op != 3'b101);
  assign w_last     = (r_iter == r_rep);
  assign w_carry_op = (r_op == 3'b000) || (r_op == 3'b001) || (r_op == 3'b011);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_legal ? S_EXEC : S_ERR;
      S_EXEC: if (w_last) w_next = S_WB;
      S_WB:   w_next = S_IDLE;
      S_ERR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand reads see the register file before any same-edge host write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 3'b111;
      r_rd        <= '0;
      r_rep       <= '0;
      r_iter      <= '0;
      r_carry     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_done_data <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_en) r_rf[wr_addr] <= wr_data;
          if (w_accept) begin
            r_op   <= in_op;
            r_rd   <= in_rd;
            r_rep  <= in_rep;
            r_iter <= '0;
            r_a    <= r_rf[in_rs1];
            r_b    <= r_rf[in_rs2];
            r_err  <= !w_legal;
          end
        end
        S_EXEC: begin
          r_a <= alu_out;
          if (w_carry_op) r_carry <= alu_co;
          if (w_last) begin
            r_done      <= 1'b1;
            r_done_data <= alu_out;
          end else begin
            r_iter <= r_iter + 3'd1;
          end
        end
        S_WB: r_rf[r_rd] <= r_a;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign rd_data   = r_rf[rd_addr];
  assign alu_op1   = r_a;
  assign alu_op2   = r_b;
  assign alu_sel   = r_op;
  assign done      = r_done;
  assign done_data = r_done_data;
  assign carry     = r_carry;
  assign err       = r_err;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that owns an 8x8 register file and sequences the shared 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from the register file.
- Drives the ALU for 1..8 iterations, feeding the result back as op1 on each pass, then writes the result back.
- Sits between the instruction-issue logic and the ALU instance. The ALU stays a separate combinational instance; this block only drives its ports.

Parameters:
- NREG, 8, number of registers; fixed at 8 because addresses are 3 bits.
- W, 8, data width; must match the ALU operand width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  block can accept an instruction.
- in_op  input  3  ALU select code.
- in_rd  input  3  destination register.
- in_rs1  input  3  source register for op1.
- in_rs2  input  3  source register for op2.
- in_rep  input  3  iteration count minus 1.
- wr_en  input  1  host register write.
- wr_addr  input  3  host write address.
- wr_data  input  8  host write data.
- rd_addr  input  3  debug read address.
- rd_data  output  8  combinational register file read.
- alu_op1  output  8  to ALU op1.
- alu_op2  output  8  to ALU op2.
- alu_sel  output  3  to ALU sel.
- alu_out  input  8  from ALU out.
- alu_co  input  1  from ALU co.
- done  output  1  result-valid pulse.
- done_data  output  8  written-back result.
- carry  output  1  sticky carry flag.
- err  output  1  illegal-op pulse.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All registers and A, B, iter = 0.
  - Latched op = 3'b111.
  - carry, done, err = 0; done_data = 0.
  - Aborts any operation in flight with no writeback.
- Legal ops:
  - 000 add; 001 arithmetic shift left; 010 xnor; 011 divide by 2; 110 two's complement; 111 pass op1.
  - 100 and 101 are illegal.
- ALU drive: alu_op1=A, alu_op2=B, alu_sel=latched op at all times; all three are registered outputs.
- IDLE:
  - in_ready=1.
  - wr_en writes rf[wr_addr] at the clock edge. wr_en is ignored in every other state.
  - Accept when in_valid && in_ready:
    - Latch op, rd, rep; set iter=0.
    - A<=rf[in_rs1], B<=rf[in_rs2].
    - If wr_en is also set that cycle, the write occurs and the operands read the pre-write values.
    - Legal op -> EXEC. Illegal op -> ERR.
- EXEC (in_ready=0), each cycle:
  - A<=alu_out.
  - If op is in {000, 001, 011}: carry<=alu_co. Otherwise carry holds.
  - B is constant across iterations.
  - If iter==rep -> WB; else iter<=iter+1.
- WB (one cycle):
  - done=1, done_data=A.
  - rf[rd]<=A at the end of the cycle.
  - Next state IDLE.
- ERR (one cycle):
  - err=1.
  - No register write; carry unchanged.
  - Next state IDLE.
- Latency: accept at edge T -> done high in cycle T+2+rep -> in_ready back high one cycle later.
- Throughput: one instruction per rep+3 cycles.
- done and err are high for exactly one cycle and are never high together.
- rd may equal rs1 or rs2; operands are captured at accept, so there is no hazard.
- Register 0 is an ordinary writable register.
- rd_data shows the old value during WB and the new value from the following cycle.
- Iteration wrap: rep=7 gives 8 iterations; iter never exceeds rep.
- in_valid is ignored outside IDLE. Upstream must hold the instruction until it sees in_ready.

Test Plan:
- Reset and idle: assert rst_n=0 mid-EXEC (add, rep=5).
  - Required: no done pulse, target register unchanged, in_ready=1 immediately, carry=0, alu_sel=111.
- Add with carry: load r1=200, r2=100; issue add rd=3 rs1=1 rs2=2 rep=0.
  - Required: done in cycle T+2 with done_data=44 (0x2C); r3=44; carry=1.
- Repeated add: r1=5, r2=3; add rd=4 rs1=1 rs2=2 rep=3.
  - Required: done at T+5; r4=17; carry=0.
- Repeated shift: r1=0x05; op 001 rd=1 rs1=1 rep=2.
  - Required: r1=0x28 after done; carry=0.
  - rd_data(1) reads 0x05 during WB and 0x28 the following cycle.
- Illegal op and flag hold: after the add-with-carry case (carry=1), issue op 100.
  - Required: err pulse at T+1, no done, no register change, carry stays 1.
  - Then issue op 010 (xnor) on r1=0xF0, r2=0x0F -> result 0x00, carry still 1.
- Back-to-back and write collision: hold in_valid high with two instructions, asserting wr_en during EXEC.
  - Required: second instruction accepted exactly one cycle after the first done; wr_en ignored.
  - In IDLE with accept plus wr_en to rs1: operand uses the old value and the write still lands.
